// File: rtl/mmu_pkg.sv
// Shared types and widths for the MMU load/store sequencer.
package mmu_pkg;

  localparam int REG_ADDR_W     = 4;
  localparam int MEM_ADDR_W     = 4;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } mmu_state_e;

endpackage

// File: rtl/mmu_timeout_ctr.sv
// Counts cycles spent waiting in REQ; expired marks the TIMEOUT-th REQ cycle.
module mmu_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // count is 0 in the first REQ cycle, so TIMEOUT-1 marks the last allowed one
  assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mmu_sequencer.sv
// Sequences one decoded load/store at a time through memory and register writeback.
// Optional REQ timeout is enabled by defining MMU_SEQ_TIMEOUT_EN.
module mmu_sequencer
  import mmu_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_ld,
  input  logic                  cmd_st,
  input  logic [REG_ADDR_W-1:0] cmd_reg_addr,
  input  logic [MEM_ADDR_W-1:0] cmd_mem_addr,
  input  logic [DATA_W-1:0]     st_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  busy,
  output logic                  ill,
  output logic                  tmo
);

  mmu_state_e state, state_nxt;

  logic                  ld_q;
  logic [REG_ADDR_W-1:0] reg_addr_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  ill_q;
  logic                  accept;
  logic                  legal;
  logic                  timeout_hit;

  assign accept = cmd_valid && (state == IDLE);
  assign legal  = cmd_ld ^ cmd_st;

`ifdef MMU_SEQ_TIMEOUT_EN
  logic ctr_expired;
  logic tmo_q;

  mmu_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept && legal),
    .enable (state == REQ),
    .expired(ctr_expired)
  );

  assign timeout_hit = (state == REQ) && ctr_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= timeout_hit && !mem_ack;
    end
  end

  assign tmo = tmo_q;
`else
  assign timeout_hit = 1'b0;
  assign tmo         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ld_q       <= 1'b0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ill_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      ill_q <= accept && !legal;
      if (accept && legal) begin
        ld_q       <= cmd_ld;
        reg_addr_q <= cmd_reg_addr;
        mem_addr_q <= cmd_mem_addr;
        wdata_q    <= st_data;
      end
      if ((state == REQ) && mem_ack && ld_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // An ack in the last allowed REQ cycle wins over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && legal) state_nxt = REQ;
      REQ: begin
        if (mem_ack)          state_nxt = ld_q ? WB : IDLE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mem_req   = (state == REQ);
  assign mem_we    = (state == REQ) && !ld_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign rf_we     = (state == WB);
  assign rf_waddr  = reg_addr_q;
  assign rf_wdata  = rdata_q;
  assign ill       = ill_q;

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed self-checking bench for mmu_sequencer (default and MMU_SEQ_TIMEOUT_EN builds).
module tb_mmu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_ld;
  logic        cmd_st;
  logic [3:0]  cmd_reg_addr;
  logic [3:0]  cmd_mem_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        ill;
  logic        tmo;

  int tests_run    = 0;
  int tests_failed = 0;
  int overlap_cnt  = 0;

  mmu_sequencer #(.DATA_W(32), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ld      (cmd_ld),
    .cmd_st      (cmd_st),
    .cmd_reg_addr(cmd_reg_addr),
    .cmd_mem_addr(cmd_mem_addr),
    .st_data     (st_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .ill         (ill),
    .tmo         (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rf_we, mem_req, ill and tmo are mutually exclusive in every cycle
  always @(negedge clk) begin
    if ($countones({rf_we, mem_req, ill, tmo}) > 1) overlap_cnt++;
  end

  task automatic drive_cmd(input logic ld, input logic st, input logic [3:0] ra,
                           input logic [3:0] ma, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_ld = ld; cmd_st = st;
    cmd_reg_addr = ra; cmd_mem_addr = ma; st_data = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cmd_ready: got %0h want 1", cmd_ready); end
    tests_run++; if ({busy, mem_req, mem_we, rf_we, ill, tmo} !== 6'b0) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b want 000000", {busy, mem_req, mem_we, rf_we, ill, tmo}); end
    tests_run++; if ({mem_addr, mem_wdata, rf_waddr, rf_wdata} !== 72'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, rf_waddr, rf_wdata}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load;
    drive_cmd(1'b1, 1'b0, 4'd3, 4'd5, 32'h0);
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_ready_T: got %0h want 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tests_run++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 4'd5}) begin tests_failed++; $display("[TB] FAIL load_req: got %b want 1_0_0101", {mem_req, mem_we, mem_addr}); end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tests_run++; if ({rf_we, rf_waddr, mem_req} !== {1'b1, 4'd3, 1'b0}) begin tests_failed++; $display("[TB] FAIL load_wb: got %b want 1_0011_0", {rf_we, rf_waddr, mem_req}); end
    tests_run++; if (rf_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL load_wdata: got %h want deadbeef", rf_wdata); end
    tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_ready_wb: got %0h want 0", cmd_ready); end
    @(negedge clk);
    tests_run++; if ({cmd_ready, rf_we} !== 2'b10) begin tests_failed++; $display("[TB] FAIL load_done: got %b want 10", {cmd_ready, rf_we}); end
  endtask

  task automatic test_store;
    drive_cmd(1'b0, 1'b1, 4'd7, 4'd9, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0; st_data = 32'hFFFF0000; mem_rdata = 32'hCAFE0000 + 32'(i);
      mem_ack = (i == 3);
      tests_run++; if ({mem_req, mem_we, mem_addr, rf_we} !== {1'b1, 1'b1, 4'd9, 1'b0}) begin tests_failed++; $display("[TB] FAIL store_hold%0d: got %b want 1_1_1001_0", i, {mem_req, mem_we, mem_addr, rf_we}); end
      tests_run++; if (mem_wdata !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL store_wdata%0d: got %h want 12345678", i, mem_wdata); end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    tests_run++; if ({cmd_ready, mem_req, rf_we} !== 3'b100) begin tests_failed++; $display("[TB] FAIL store_done: got %b want 100", {cmd_ready, mem_req, rf_we}); end
    @(negedge clk);
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_no_wb: got %0h want 0", rf_we); end
  endtask

  task automatic test_illegal;
    drive_cmd(1'b1, 1'b1, 4'd1, 4'd1, 32'h0);
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 4'd2, 4'd2, 32'h0);
    tests_run++; if ({ill, mem_req, cmd_ready} !== 3'b101) begin tests_failed++; $display("[TB] FAIL ill_first: got %b want 101", {ill, mem_req, cmd_ready}); end
    @(negedge clk);
    cmd_valid = 1'b0;
    tests_run++; if ({ill, mem_req, cmd_ready} !== 3'b101) begin tests_failed++; $display("[TB] FAIL ill_second: got %b want 101", {ill, mem_req, cmd_ready}); end
    @(negedge clk);
    tests_run++; if ({ill, mem_req, busy} !== 3'b000) begin tests_failed++; $display("[TB] FAIL ill_clear: got %b want 000", {ill, mem_req, busy}); end
  endtask

  task automatic test_ack_idle;
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if ({busy, rf_we, mem_req} !== 3'b000) begin tests_failed++; $display("[TB] FAIL ack_idle: got %b want 000", {busy, rf_we, mem_req}); end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    int tmo_pulses = 0;
    int wb_cycles  = 0;
    drive_cmd(1'b1, 1'b0, 4'd2, 4'd4, 32'h0);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (mem_req) req_cycles++;
      if (tmo) tmo_pulses++;
      if (rf_we) wb_cycles++;
    end
`ifdef MMU_SEQ_TIMEOUT_EN
    tests_run++; if (req_cycles != 15) begin tests_failed++; $display("[TB] FAIL tmo_req_cycles: got %0d want 15", req_cycles); end
    tests_run++; if (tmo_pulses != 1) begin tests_failed++; $display("[TB] FAIL tmo_pulses: got %0d want 1", tmo_pulses); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL tmo_idle: got %0h want 0", busy); end
`else
    tests_run++; if (req_cycles != 120) begin tests_failed++; $display("[TB] FAIL wait_req_cycles: got %0d want 120", req_cycles); end
    tests_run++; if (tmo_pulses != 0) begin tests_failed++; $display("[TB] FAIL wait_tmo: got %0d want 0", tmo_pulses); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL wait_busy: got %0h want 1", busy); end
`endif
    tests_run++; if (wb_cycles != 0) begin tests_failed++; $display("[TB] FAIL tmo_no_wb: got %0d want 0", wb_cycles); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int wb_cycles = 0;
    drive_cmd(1'b1, 1'b0, 4'd6, 4'd1, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmid_req: got %0h want 1", mem_req); end
    rst_n = 1'b0;
    #1;
    tests_run++; if ({mem_req, busy, cmd_ready, mem_addr} !== {3'b001, 4'd0}) begin tests_failed++; $display("[TB] FAIL rmid_clear: got %b want 001_0000", {mem_req, busy, cmd_ready, mem_addr}); end
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rf_we) wb_cycles++;
    end
    mem_ack = 1'b0;
    tests_run++; if (wb_cycles != 0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_late_ack: got wb=%0d busy=%0h want 0 0", wb_cycles, busy); end
  endtask

  task automatic test_back_to_back;
    drive_cmd(1'b1, 1'b0, 4'd1, 4'd2, 32'h0);
    @(negedge clk);
    drive_cmd(1'b0, 1'b1, 4'd0, 4'd3, 32'h00000055);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    tests_run++; if ({cmd_ready, mem_we, mem_addr} !== {2'b00, 4'd2}) begin tests_failed++; $display("[TB] FAIL b2b_load_req: got %b want 00_0010", {cmd_ready, mem_we, mem_addr}); end
    @(negedge clk);
    mem_ack = 1'b0;
    tests_run++; if ({rf_we, rf_waddr, cmd_ready} !== {1'b1, 4'd1, 1'b0}) begin tests_failed++; $display("[TB] FAIL b2b_wb: got %b want 1_0001_0", {rf_we, rf_waddr, cmd_ready}); end
    tests_run++; if (rf_wdata !== 32'h0BADF00D) begin tests_failed++; $display("[TB] FAIL b2b_wdata: got %h want 0badf00d", rf_wdata); end
    @(negedge clk);
    tests_run++; if ({cmd_ready, rf_we, mem_req} !== 3'b100) begin tests_failed++; $display("[TB] FAIL b2b_ready: got %b want 100", {cmd_ready, rf_we, mem_req}); end
    @(negedge clk);
    cmd_valid = 1'b0; mem_ack = 1'b1;
    tests_run++; if ({mem_req, mem_we, mem_addr} !== {2'b11, 4'd3}) begin tests_failed++; $display("[TB] FAIL b2b_store_req: got %b want 11_0011", {mem_req, mem_we, mem_addr}); end
    tests_run++; if (mem_wdata !== 32'h00000055) begin tests_failed++; $display("[TB] FAIL b2b_store_data: got %h want 00000055", mem_wdata); end
    @(negedge clk);
    mem_ack = 1'b0;
    tests_run++; if ({busy, mem_req, rf_we} !== 3'b000) begin tests_failed++; $display("[TB] FAIL b2b_done: got %b want 000", {busy, mem_req, rf_we}); end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_single_accept: got %0h want 0", busy); end
  endtask

  task automatic test_exclusive;
    tests_run++; if (overlap_cnt != 0) begin tests_failed++; $display("[TB] FAIL exclusive_outputs: got %0d overlapping cycles want 0", overlap_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_st = 1'b0;
    cmd_reg_addr = 4'd0; cmd_mem_addr = 4'd0; st_data = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_load();
    test_store();
    test_illegal();
    test_ack_idle();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
